// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM port arbiter: FSM states, the no-grant value
// and the client index constants.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'd3;
  localparam logic [1:0] C_VGA      = 2'd0;
  localparam logic [1:0] C_RD       = 2'd1;
  localparam logic [1:0] C_WR       = 2'd2;

endpackage

// File: rtl/sdram_arb_pick.sv
// Winner selection: VGA client by default, with a cap on back-to-back VGA wins
// while the CPU pair waits; the CPU pair alternates via a last-served pointer.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int VGA_MAX_CONSEC = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] req_i,
  input  logic       take_i,
  input  logic       clear_i,
  output logic [1:0] win_o,
  output logic       any_o
);

  localparam int CW = $clog2(VGA_MAX_CONSEC + 1);

  logic [CW-1:0] consec_q, consec_d;
  logic          pref_wr_q, pref_wr_d;
  logic          rr_any;
  logic          vga_capped;
  logic [1:0]    rr_win;

  assign any_o      = |req_i;
  assign rr_any     = req_i[C_RD] | req_i[C_WR];
  assign vga_capped = (consec_q >= CW'(VGA_MAX_CONSEC)) & rr_any;

  always_comb begin
    rr_win = req_i[C_RD] ? C_RD : C_WR;
    if (req_i[C_RD] && req_i[C_WR]) rr_win = pref_wr_q ? C_WR : C_RD;
    win_o = (req_i[C_VGA] && !vga_capped) ? C_VGA : rr_win;
  end

  // The consecutive counter saturates; it only matters once it reaches the cap.
  always_comb begin
    consec_d  = consec_q;
    pref_wr_d = pref_wr_q;
    if (take_i) begin
      if (win_o == C_VGA) begin
        if (consec_q != CW'(VGA_MAX_CONSEC)) consec_d = consec_q + 1'b1;
      end else begin
        consec_d  = '0;
        pref_wr_d = (win_o == C_RD);
      end
    end else if (clear_i) begin
      consec_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      consec_q  <= '0;
      pref_wr_q <= 1'b0;
    end else begin
      consec_q  <= consec_d;
      pref_wr_q <= pref_wr_d;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the single sdram_controller rd/wr port between the VGA burst reader
// and the CPU cache fill / write-back clients.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW             = 24,
  parameter int BW             = 10,
  parameter int VGA_MAX_CONSEC = 4,
  parameter int TIMEOUT        = 1023
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          init_done,
  input  logic          c0_req,
  input  logic          c0_we,
  input  logic [AW-1:0] c0_addr,
  input  logic [BW-1:0] c0_burst,
  input  logic [15:0]   c0_wdata,
  output logic          c0_wdata_rd,
  output logic          c0_rdata_vld,
  output logic          c0_done,
  output logic          c0_err,
  input  logic          c1_req,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_addr,
  input  logic [BW-1:0] c1_burst,
  input  logic [15:0]   c1_wdata,
  output logic          c1_wdata_rd,
  output logic          c1_rdata_vld,
  output logic          c1_done,
  output logic          c1_err,
  input  logic          c2_req,
  input  logic          c2_we,
  input  logic [AW-1:0] c2_addr,
  input  logic [BW-1:0] c2_burst,
  input  logic [15:0]   c2_wdata,
  output logic          c2_wdata_rd,
  output logic          c2_rdata_vld,
  output logic          c2_done,
  output logic          c2_err,
  output logic [15:0]   rdata,
  output logic          ctl_wr_req,
  output logic          ctl_rd_req,
  input  logic          ctl_wr_ack,
  input  logic          ctl_rd_ack,
  output logic [AW-1:0] ctl_wr_addr,
  output logic [AW-1:0] ctl_rd_addr,
  output logic [BW-1:0] ctl_wr_burst,
  output logic [BW-1:0] ctl_rd_burst,
  output logic [15:0]   ctl_din,
  input  logic [15:0]   ctl_dout,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          we_q, we_d, err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [BW:0]   cnt_q, cnt_d, cnt_inc;
  logic [WW-1:0] wait_q, wait_d;

  logic [1:0]    pick_win;
  logic          pick_any, take, active, dir_ack, wr_stb, rd_stb, done_stb;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [BW-1:0] sel_burst;

  assign take    = (state_q == IDLE) & init_done & pick_any;
  assign active  = (state_q == ISSUE) | (state_q == XFER);
  assign dir_ack = we_q ? ctl_wr_ack : ctl_rd_ack;
  assign cnt_inc = cnt_q + 1'b1;

  sdram_arb_pick #(.VGA_MAX_CONSEC(VGA_MAX_CONSEC)) u_pick (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req_i    ({c2_req, c1_req, c0_req}),
    .take_i   (take),
    .clear_i  ((state_q == IDLE) & ~pick_any),
    .win_o    (pick_win),
    .any_o    (pick_any)
  );

  always_comb begin
    sel_we    = c0_we;
    sel_addr  = c0_addr;
    sel_burst = c0_burst;
    case (pick_win)
      C_RD:    begin sel_we = c1_we; sel_addr = c1_addr; sel_burst = c1_burst; end
      C_WR:    begin sel_we = c2_we; sel_addr = c2_addr; sel_burst = c2_burst; end
      default: ;
    endcase
  end

  // The acking cycle in ISSUE is word 1; a zero-length burst never reaches the controller.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (take) begin
        grant_d = pick_win;
        we_d    = sel_we;
        addr_d  = sel_addr;
        burst_d = sel_burst;
        cnt_d   = '0;
        wait_d  = '0;
        err_d   = (sel_burst == '0);
        state_d = (sel_burst == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (dir_ack) begin
          cnt_d   = (BW+1)'(1);
          state_d = (burst_q == BW'(1)) ? DONE : XFER;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      XFER: if (dir_ack) begin
        cnt_d = cnt_inc;
        if (cnt_inc == {1'b0, burst_q}) state_d = DONE;
      end
      DONE: begin
        grant_d = GRANT_NONE;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      grant_q <= GRANT_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Controller side: requests decode straight from state so reset drops them at once.
  assign ctl_rd_req   = (state_q == ISSUE) & ~we_q;
  assign ctl_wr_req   = (state_q == ISSUE) & we_q;
  assign ctl_rd_addr  = addr_q;
  assign ctl_wr_addr  = addr_q;
  assign ctl_rd_burst = burst_q;
  assign ctl_wr_burst = burst_q;
  assign rdata        = ctl_dout;

  always_comb begin
    ctl_din = '0;
    case (grant_q)
      C_VGA:   ctl_din = c0_wdata;
      C_RD:    ctl_din = c1_wdata;
      C_WR:    ctl_din = c2_wdata;
      default: ctl_din = '0;
    endcase
  end

  assign wr_stb   = active & we_q & ctl_wr_ack;
  assign rd_stb   = active & ~we_q & ctl_rd_ack;
  assign done_stb = (state_q == DONE);

  assign c0_wdata_rd  = wr_stb & (grant_q == C_VGA);
  assign c1_wdata_rd  = wr_stb & (grant_q == C_RD);
  assign c2_wdata_rd  = wr_stb & (grant_q == C_WR);
  assign c0_rdata_vld = rd_stb & (grant_q == C_VGA);
  assign c1_rdata_vld = rd_stb & (grant_q == C_RD);
  assign c2_rdata_vld = rd_stb & (grant_q == C_WR);
  assign c0_done      = done_stb & (grant_q == C_VGA);
  assign c1_done      = done_stb & (grant_q == C_RD);
  assign c2_done      = done_stb & (grant_q == C_WR);
  assign c0_err       = c0_done & err_q;
  assign c1_err       = c1_done & err_q;
  assign c2_err       = c2_done & err_q;

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: transaction-level model with a per-cycle compare,
// directed scenarios and hand-computed literal expectations.
module tb_sdram_port_arbiter;

  localparam int AW = 24;
  localparam int BW = 10;
  localparam int VGA_MAX_CONSEC = 4;
  localparam int TIMEOUT = 1023;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          init_done = 1'b0;
  logic [2:0]    c_req = '0;
  logic [2:0]    c_we = '0;
  logic [AW-1:0] c_addr [3];
  logic [BW-1:0] c_burst [3];
  logic [15:0]   c_wdata [3];
  logic          ctl_wr_ack = 1'b0, ctl_rd_ack = 1'b0;
  logic [15:0]   ctl_dout = '0;

  wire [2:0]    c_wdata_rd, c_rdata_vld, c_done, c_err;
  wire [15:0]   rdata, ctl_din;
  wire          ctl_wr_req, ctl_rd_req, busy;
  wire [AW-1:0] ctl_wr_addr, ctl_rd_addr;
  wire [BW-1:0] ctl_wr_burst, ctl_rd_burst;
  wire [1:0]    grant, dbg_state;

  sdram_port_arbiter #(.AW(AW), .BW(BW), .VGA_MAX_CONSEC(VGA_MAX_CONSEC), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
    .c0_req(c_req[0]), .c0_we(c_we[0]), .c0_addr(c_addr[0]), .c0_burst(c_burst[0]), .c0_wdata(c_wdata[0]),
    .c0_wdata_rd(c_wdata_rd[0]), .c0_rdata_vld(c_rdata_vld[0]), .c0_done(c_done[0]), .c0_err(c_err[0]),
    .c1_req(c_req[1]), .c1_we(c_we[1]), .c1_addr(c_addr[1]), .c1_burst(c_burst[1]), .c1_wdata(c_wdata[1]),
    .c1_wdata_rd(c_wdata_rd[1]), .c1_rdata_vld(c_rdata_vld[1]), .c1_done(c_done[1]), .c1_err(c_err[1]),
    .c2_req(c_req[2]), .c2_we(c_we[2]), .c2_addr(c_addr[2]), .c2_burst(c_burst[2]), .c2_wdata(c_wdata[2]),
    .c2_wdata_rd(c_wdata_rd[2]), .c2_rdata_vld(c_rdata_vld[2]), .c2_done(c_done[2]), .c2_err(c_err[2]),
    .rdata(rdata), .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req),
    .ctl_wr_ack(ctl_wr_ack), .ctl_rd_ack(ctl_rd_ack),
    .ctl_wr_addr(ctl_wr_addr), .ctl_rd_addr(ctl_rd_addr),
    .ctl_wr_burst(ctl_wr_burst), .ctl_rd_burst(ctl_rd_burst),
    .ctl_din(ctl_din), .ctl_dout(ctl_dout), .grant(grant), .busy(busy), .dbg_state(dbg_state)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One transaction at a time: who owns the port, how many words remain,
  // how long we have waited for the first word, and whether this is the
  // completion cycle.
  int            m_cli = -1;
  bit            m_we, m_started, m_finish, m_err, m_pref2;
  int            m_left, m_waited, m_consec, m_w;
  logic [AW-1:0] m_addr = '0;
  logic [BW-1:0] m_burst = '0;

  function automatic int model_pick();
    bit others = c_req[1] || c_req[2];
    if (c_req[0] && !(m_consec >= VGA_MAX_CONSEC && others)) return 0;
    if (c_req[1] && c_req[2]) return m_pref2 ? 2 : 1;
    return c_req[1] ? 1 : 2;
  endfunction

  initial forever begin
    @(posedge sys_clk or negedge sys_rst_n);
    if (!sys_rst_n) begin
      m_cli = -1; m_we = 0; m_started = 0; m_finish = 0; m_err = 0;
      m_pref2 = 0; m_left = 0; m_waited = 0; m_consec = 0;
      m_addr = '0; m_burst = '0;
    end else if (m_finish) begin
      m_finish = 0; m_err = 0; m_cli = -1;
    end else if (m_cli < 0) begin
      if (init_done && c_req != 3'b000) begin
        m_w = model_pick();
        if (m_w == 0) m_consec++;
        else begin m_consec = 0; m_pref2 = (m_w == 1); end
        m_cli = m_w; m_we = c_we[m_w]; m_addr = c_addr[m_w]; m_burst = c_burst[m_w];
        m_left = int'(c_burst[m_w]); m_waited = 0; m_started = 0;
        m_err = (m_left == 0); m_finish = (m_left == 0);
      end else if (c_req == 3'b000) begin
        m_consec = 0;
      end
    end else begin
      if (m_we ? ctl_wr_ack : ctl_rd_ack) begin
        m_left--; m_started = 1;
        if (m_left == 0) m_finish = 1;
      end else if (!m_started) begin
        m_waited++;
        if (m_waited == TIMEOUT) begin m_finish = 1; m_err = 1; end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  bit m_act;
  initial forever begin
    @(negedge sys_clk);
    m_act = (m_cli >= 0) && !m_finish;
    chk("grant", grant, (m_cli < 0) ? 3 : m_cli);
    chk("busy", busy, m_cli >= 0);
    chk("ctl_rd_req", ctl_rd_req, m_act && !m_started && !m_we);
    chk("ctl_wr_req", ctl_wr_req, m_act && !m_started && m_we);
    chk("ctl_rd_addr", ctl_rd_addr, m_addr);
    chk("ctl_wr_addr", ctl_wr_addr, m_addr);
    chk("ctl_rd_burst", ctl_rd_burst, m_burst);
    chk("ctl_wr_burst", ctl_wr_burst, m_burst);
    chk("rdata", rdata, ctl_dout);
    chk("ctl_din", ctl_din, (m_cli >= 0) ? c_wdata[m_cli] : 16'h0);
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("c%0d_wdata_rd", n), c_wdata_rd[n], m_act && m_cli == n && m_we && ctl_wr_ack);
      chk($sformatf("c%0d_rdata_vld", n), c_rdata_vld[n], m_act && m_cli == n && !m_we && ctl_rd_ack);
      chk($sformatf("c%0d_done", n), c_done[n], m_finish && m_cli == n);
      chk($sformatf("c%0d_err", n), c_err[n], m_finish && m_cli == n && m_err);
    end
  end

  // ---------------- monitors / scoreboard ----------------
  int          n_rdreq, n_wrreq;
  int          n_wstb [3];
  logic [15:0] got_rd[$];
  logic [15:0] got_din[$];
  logic [15:0] exp_q[$];
  int          gseq[$];
  logic [1:0]  prev_grant = 2'd3;

  initial forever begin
    @(negedge sys_clk);
    if (ctl_rd_req) n_rdreq++;
    if (ctl_wr_req) n_wrreq++;
    for (int n = 0; n < 3; n++) if (c_wdata_rd[n]) n_wstb[n]++;
    if (c_rdata_vld[1]) got_rd.push_back(rdata);
    if (c_wdata_rd[2]) got_din.push_back(ctl_din);
    if (grant != 2'd3 && prev_grant == 2'd3) gseq.push_back(int'(grant));
    prev_grant = grant;
  end

  task automatic clear_mon();
    n_rdreq = 0; n_wrreq = 0;
    for (int n = 0; n < 3; n++) n_wstb[n] = 0;
    got_rd.delete(); got_din.delete(); exp_q.delete(); gseq.delete();
  endtask

  task automatic sb_compare(input string nm, input logic [15:0] got[$]);
    chk({nm, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", nm, i), got[i], exp_q[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic request(input int n, input bit we, input logic [AW-1:0] addr, input logic [BW-1:0] bl);
    c_we[n] = we; c_addr[n] = addr; c_burst[n] = bl; c_req[n] = 1'b1;
  endtask

  task automatic set_ack(input bit we, input bit v);
    if (we) ctl_wr_ack = v; else ctl_rd_ack = v;
  endtask

  // Controller side: wait for the request, then ack 'words' words, optionally
  // stalling stall_len cycles before word stall_at.
  task automatic serve(input bit we, input int n, input int words, input int stall_at,
                       input int stall_len, input logic [15:0] base);
    int guard = 0;
    while (!(we ? ctl_wr_req : ctl_rd_req) && guard < 20) begin tick(1); guard++; end
    chk("serve_req_seen", guard < 20, 1'b1);
    for (int k = 0; k < words; k++) begin
      c_wdata[n] = base + 16'(k);
      if (k == stall_at) begin set_ack(we, 1'b0); tick(stall_len); end
      ctl_dout = base + 16'(k);
      set_ack(we, 1'b1);
      tick(1);
    end
    set_ack(we, 1'b0);
  endtask

  task automatic wait_done(input int n, input int limit, output logic err);
    bit seen = 0;
    err = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge sys_clk);
      if (c_done[n]) begin seen = 1; err = c_err[n]; c_req[n] = 1'b0; end
    end
    chk($sformatf("done_seen_c%0d", n), seen, 1'b1);
    tick(1);
  endtask

  task automatic wait_grants(input int cnt, input int limit);
    int i = 0;
    while (gseq.size() < cnt && i < limit) begin tick(1); i++; end
    chk("grant_seq_len", gseq.size() >= cnt, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  logic err;
  int   exp_g [20];

  initial begin
    for (int n = 0; n < 3; n++) begin c_addr[n] = '0; c_burst[n] = '0; c_wdata[n] = '0; end
    clear_mon();
    tick(3);
    chk("reset_grant", grant, 2'd3);
    chk("reset_busy", busy, 1'b0);
    chk("reset_state", dbg_state, 2'd0);
    chk("reset_ctl_rd_req", ctl_rd_req, 1'b0);
    sys_rst_n = 1'b1;
    init_done = 1'b1;
    tick(2);

    // Single read: c1, burst 4 at 0x000100
    clear_mon();
    request(1, 1'b0, 24'h000100, 10'd4);
    tick(1);
    chk("t1_rd_addr", ctl_rd_addr, 24'h000100);
    chk("t1_rd_burst", ctl_rd_burst, 10'd4);
    chk("t1_grant", grant, 2'd1);
    serve(1'b0, 1, 4, -1, 0, 16'h00A0);
    wait_done(1, 10, err);
    chk("t1_err", err, 1'b0);
    exp_q = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    sb_compare("t1_rdata", got_rd);
    tick(2);

    // Write burst 8 from c2, then again with a 2-cycle stall
    for (int rep = 0; rep < 2; rep++) begin
      clear_mon();
      request(2, 1'b1, 24'h00ABC0, 10'd8);
      tick(1);
      chk("t2_wr_addr", ctl_wr_addr, 24'h00ABC0);
      serve(1'b1, 2, 8, rep ? 3 : -1, 2, 16'hB000);
      wait_done(2, 10, err);
      chk("t2_err", err, 1'b0);
      chk("t2_strobes", n_wstb[2], 8);
      chk("t2_wr_req_cycles", n_wrreq, 1);
      for (int i = 0; i < 8; i++) exp_q.push_back(16'hB000 + 16'(i));
      sb_compare("t2_din", got_din);
      tick(2);
    end

    // Starvation guard: c0 and c1 continuously, then c2 joins
    clear_mon();
    c_wdata[0] = 16'h1111; c_wdata[2] = 16'h2222;
    ctl_rd_ack = 1'b1; ctl_wr_ack = 1'b1;
    c_we[0] = 1'b0; c_burst[0] = 10'd1; c_addr[0] = 24'h000200;
    c_we[1] = 1'b0; c_burst[1] = 10'd1; c_addr[1] = 24'h000300;
    c_we[2] = 1'b1; c_burst[2] = 10'd1; c_addr[2] = 24'h000400;
    c_req[0] = 1'b1; c_req[1] = 1'b1;
    wait_grants(10, 200);
    c_req[2] = 1'b1;
    wait_grants(20, 200);
    c_req = '0;
    tick(6);
    ctl_rd_ack = 1'b0; ctl_wr_ack = 1'b0;
    exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1};
    for (int i = 0; i < 20 && i < gseq.size(); i++) chk($sformatf("starve_g%0d", i), gseq[i], exp_g[i]);
    tick(2);

    // Timeout: c1 read never acked
    clear_mon();
    request(1, 1'b0, 24'h000500, 10'd4);
    wait_done(1, TIMEOUT + 50, err);
    chk("t5_err", err, 1'b1);
    chk("t5_rd_req_cycles", n_rdreq, TIMEOUT);
    chk("t5_grant_after", grant, 2'd3);
    tick(2);

    // Burst 0: immediate done+err, controller untouched
    clear_mon();
    request(1, 1'b0, 24'h000600, 10'd0);
    wait_done(1, 10, err);
    chk("t6_err", err, 1'b1);
    chk("t6_no_ctl_req", n_rdreq + n_wrreq, 0);
    tick(2);

    // init_done low blocks grants; c0 burst 2 once it rises
    clear_mon();
    init_done = 1'b0;
    request(0, 1'b0, 24'h000700, 10'd2);
    tick(5);
    chk("t7_no_grant", grant, 2'd3);
    chk("t7_not_busy", busy, 1'b0);
    init_done = 1'b1;
    tick(1);
    chk("t7_grant", grant, 2'd0);
    serve(1'b0, 0, 2, -1, 0, 16'h00C0);
    wait_done(0, 10, err);
    chk("t7_err", err, 1'b0);
    tick(2);

    // Reset during word 3 of an 8-word write
    clear_mon();
    request(2, 1'b1, 24'h000800, 10'd8);
    tick(1);
    c_wdata[2] = 16'hD000; ctl_wr_ack = 1'b1;
    tick(2);
    c_wdata[2] = 16'hD002;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t8_wr_req", ctl_wr_req, 1'b0);
    chk("t8_wstb", c_wdata_rd, 3'b000);
    chk("t8_done", c_done, 3'b000);
    chk("t8_grant", grant, 2'd3);
    chk("t8_busy", busy, 1'b0);
    chk("t8_strobes_before", n_wstb[2], 2);
    c_req = '0; ctl_wr_ack = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard time limit so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
